// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 Hz raster constants. The timing generator and every
//   sprite/region consumer take the blanking offsets from here rather than
//   hard-coding 144/34.
package vga_timing_pkg;

  localparam int CNT_W    = 10;

  // System clocks per pixel: 100 MHz / 4 = 25 MHz.
  localparam int PIX_DIV  = 4;

  // Horizontal segments in pixels.
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;

  // Vertical segments in lines.
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 32;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 11;

  localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;  // 800
  localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;  // 525

  // First visible column/row, measured from the start of sync.
  localparam int H_VIS_START = H_SYNC + H_BACK;                    // 144
  localparam int V_VIS_START = V_SYNC + V_BACK;                    // 34

endpackage

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// pix_tick_gen
//   Divides clk by PIX_DIV to produce the pixel cadence.
//   Ports:
//     clk        in   system clock
//     resetN     in   asynchronous active-low reset
//     pixAdvance out  combinational: counters step on the coming edge
//     pixTick    out  registered: high for the one clk after each step
module pix_tick_gen
  import vga_timing_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  output logic pixAdvance,
  output logic pixTick
);

  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);

  logic [1:0] div;

  assign pixAdvance = (div == DIV_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div     <= '0;
      pixTick <= 1'b0;
    end else begin
      div     <= pixAdvance ? 2'd0 : div + 2'd1;
      pixTick <= pixAdvance;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster counters with sync and visible-area decode.
//   Segment lengths default to the 640x480@60 values in vga_timing_pkg.
//   Ports:
//     clk        in   system clock (100 MHz)
//     resetN     in   asynchronous active-low reset
//     hCount     out  horizontal position, 0..H_TOTAL-1
//     vCount     out  vertical position, 0..V_TOTAL-1
//     hSync      out  active-low horizontal sync
//     vSync      out  active-low vertical sync
//     bright     out  pixel lies in the visible area
//     pixTick    out  one-clk pulse when the counters have just advanced
//     frameStart out  one-clk pulse when the counters have just wrapped to (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC_PX   = H_SYNC,
  parameter int H_BACK_PX   = H_BACK,
  parameter int H_ACTIVE_PX = H_ACTIVE,
  parameter int H_FRONT_PX  = H_FRONT,
  parameter int V_SYNC_LN   = V_SYNC,
  parameter int V_BACK_LN   = V_BACK,
  parameter int V_ACTIVE_LN = V_ACTIVE,
  parameter int V_FRONT_LN  = V_FRONT
)(
  input  logic             clk,
  input  logic             resetN,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             pixTick,
  output logic             frameStart
);

  localparam int H_TOT = H_SYNC_PX + H_BACK_PX + H_ACTIVE_PX + H_FRONT_PX;
  localparam int V_TOT = V_SYNC_LN + V_BACK_LN + V_ACTIVE_LN + V_FRONT_LN;

  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC_PX);
  localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC_LN);
  localparam logic [CNT_W-1:0] H_VIS_FIRST = CNT_W'(H_SYNC_PX + H_BACK_PX);
  localparam logic [CNT_W-1:0] H_VIS_LAST  = CNT_W'(H_SYNC_PX + H_BACK_PX + H_ACTIVE_PX - 1);
  localparam logic [CNT_W-1:0] V_VIS_FIRST = CNT_W'(V_SYNC_LN + V_BACK_LN);
  localparam logic [CNT_W-1:0] V_VIS_LAST  = CNT_W'(V_SYNC_LN + V_BACK_LN + V_ACTIVE_LN - 1);

  logic             pixAdvance;
  logic [CNT_W-1:0] hNext;
  logic [CNT_W-1:0] vNext;
  logic             frameWrap;
  logic             brightNext;

  pix_tick_gen uPixTick (
    .clk        (clk),
    .resetN     (resetN),
    .pixAdvance (pixAdvance),
    .pixTick    (pixTick)
  );

  always_comb begin
    hNext     = hCount;
    vNext     = vCount;
    frameWrap = 1'b0;
    if (pixAdvance) begin
      if (hCount == H_LAST) begin
        hNext = '0;
        if (vCount == V_LAST) begin
          vNext     = '0;
          frameWrap = 1'b1;
        end else begin
          vNext = vCount + 1'b1;
        end
      end else begin
        hNext = hCount + 1'b1;
      end
    end
  end

  // Decoding the next-state counts keeps sync/bright aligned with the
  // counts they describe, all leaving the same flops.
  assign brightNext = (hNext >= H_VIS_FIRST) && (hNext <= H_VIS_LAST) &&
                      (vNext >= V_VIS_FIRST) && (vNext <= V_VIS_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      hCount     <= hNext;
      vCount     <= vNext;
      hSync      <= (hNext >= H_SYNC_END);
      vSync      <= (vNext >= V_SYNC_END);
      bright     <= brightNext;
      frameStart <= frameWrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two instances share the clock: one at full 640x480 timing for reset,
//   line-level and mid-line reset behaviour, one with shrunken segments so
//   whole frames, the visible window and a rectangle consumer fit in a short run.
//   Every cycle both are compared with a raster model computed from the number
//   of clock edges since reset release.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int S_HS = 8, S_HB = 4, S_HA = 20, S_HF = 3;
  localparam int S_VS = 2, S_VB = 3, S_VA = 6,  S_VF = 2;
  localparam int S_HT = S_HS + S_HB + S_HA + S_HF;   // 35
  localparam int S_VT = S_VS + S_VB + S_VA + S_VF;   // 13
  localparam int S_H0 = S_HS + S_HB;                 // 12
  localparam int S_V0 = S_VS + S_VB;                 // 5
  localparam int S_FRAME_CLK = S_HT * S_VT * PIX_DIV;

  // Rectangle consumer on the small raster: x 2..7, y 1..3 past the offsets.
  localparam int R_X0 = 2, R_X1 = 7, R_Y0 = 1, R_Y1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstF = 1'b0;
  logic rstS = 1'b0;

  logic [9:0] hCountF, vCountF, hCountS, vCountS;
  logic hSyncF, vSyncF, brightF, pixTickF, frameStartF;
  logic hSyncS, vSyncS, brightS, pixTickS, frameStartS;

  vga_timing_gen dutF (
    .clk(clk), .resetN(rstF), .hCount(hCountF), .vCount(vCountF),
    .hSync(hSyncF), .vSync(vSyncF), .bright(brightF),
    .pixTick(pixTickF), .frameStart(frameStartF)
  );

  vga_timing_gen #(
    .H_SYNC_PX(S_HS), .H_BACK_PX(S_HB), .H_ACTIVE_PX(S_HA), .H_FRONT_PX(S_HF),
    .V_SYNC_LN(S_VS), .V_BACK_LN(S_VB), .V_ACTIVE_LN(S_VA), .V_FRONT_LN(S_VF)
  ) dutS (
    .clk(clk), .resetN(rstS), .hCount(hCountS), .vCount(vCountS),
    .hSync(hSyncS), .vSync(vSyncS), .bright(brightS),
    .pixTick(pixTickS), .frameStart(frameStartS)
  );

  // Edges seen since each instance left reset.
  int kF, kS;
  always @(posedge clk or negedge rstF) if (!rstF) kF <= 0; else kF <= kF + 1;
  always @(posedge clk or negedge rstS) if (!rstS) kS <= 0; else kS <= kS + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h, v, hs, vs, br, pt, fs;
  } exp_t;

  function automatic exp_t model(int k, int hs, int hb, int ha, int hf,
                                 int vs, int vb, int va, int vf);
    exp_t e;
    int ht = hs + hb + ha + hf;
    int vt = vs + vb + va + vf;
    int p  = k / PIX_DIV;
    e.h  = p % ht;
    e.v  = (p / ht) % vt;
    e.hs = (e.h >= hs) ? 1 : 0;
    e.vs = (e.v >= vs) ? 1 : 0;
    e.br = (e.h >= hs + hb && e.h < hs + hb + ha &&
            e.v >= vs + vb && e.v < vs + vb + va) ? 1 : 0;
    e.pt = (k > 0 && k % PIX_DIV == 0) ? 1 : 0;
    e.fs = (e.pt == 1 && e.h == 0 && e.v == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic checkAll();
    exp_t f, s;
    f = model(kF, H_SYNC, H_BACK, H_ACTIVE, H_FRONT, V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    s = model(kS, S_HS, S_HB, S_HA, S_HF, S_VS, S_VB, S_VA, S_VF);
    chk("F.hCount", 32'(hCountF), f.h);
    chk("F.vCount", 32'(vCountF), f.v);
    chk("F.hSync", 32'(hSyncF), f.hs);
    chk("F.vSync", 32'(vSyncF), f.vs);
    chk("F.bright", 32'(brightF), f.br);
    chk("F.pixTick", 32'(pixTickF), f.pt);
    chk("F.frameStart", 32'(frameStartF), f.fs);
    chk("S.hCount", 32'(hCountS), s.h);
    chk("S.vCount", 32'(vCountS), s.v);
    chk("S.hSync", 32'(hSyncS), s.hs);
    chk("S.vSync", 32'(vSyncS), s.vs);
    chk("S.bright", 32'(brightS), s.br);
    chk("S.pixTick", 32'(pixTickS), s.pt);
    chk("S.frameStart", 32'(frameStartS), s.fs);
  endtask

  int cyc = 0;
  int lineStart = 0;
  logic [9:0] prevHF = '0;
  logic prevHsF = 1'b0, prevBrS = 1'b0;
  bit seenFs = 0;
  int lastFs = 0, brCnt = 0, fillCnt = 0;

  task automatic syncPrev();
    prevHF  = hCountF;
    prevHsF = hSyncF;
    prevBrS = brightS;
  endtask

  task automatic cycles(input int n);
    logic fill;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      checkAll();
      if (prevHF == 10'(H_TOTAL - 1) && hCountF == 10'd0) begin
        chk("F.lineLenClk", cyc - lineStart, H_TOTAL * PIX_DIV);
        lineStart = cyc;
      end
      if (!prevHsF && hSyncF) chk("F.hSyncRiseAt", 32'(hCountF), H_SYNC);
      if (brightS && !prevBrS) chk("S.brightRiseAt", 32'(hCountS), S_H0);
      if (!brightS && prevBrS) chk("S.brightFallAt", 32'(hCountS), S_H0 + S_HA);
      fill = (int'(hCountS) >= S_H0 + R_X0) && (int'(hCountS) <= S_H0 + R_X1) &&
             (int'(vCountS) >= S_V0 + R_Y0) && (int'(vCountS) <= S_V0 + R_Y1);
      if (fill) chk("S.fillInBright", 32'(brightS), 1);
      if (frameStartS) begin
        if (seenFs) begin
          chk("S.framePeriod", cyc - lastFs, S_FRAME_CLK);
          chk("S.framePixBright", brCnt, S_HA * S_VA);
          chk("S.framePixFill", fillCnt, (R_X1 - R_X0 + 1) * (R_Y1 - R_Y0 + 1));
        end
        seenFs  = 1;
        lastFs  = cyc;
        brCnt   = 0;
        fillCnt = 0;
      end
      if (pixTickS) begin
        if (brightS) brCnt++;
        if (fill) fillCnt++;
      end
      syncPrev();
    end
  endtask

  task automatic checkFullZero(input string tag);
    chk({tag, ".hCount"}, 32'(hCountF), 0);
    chk({tag, ".vCount"}, 32'(vCountF), 0);
    chk({tag, ".hSync"}, 32'(hSyncF), 0);
    chk({tag, ".vSync"}, 32'(vSyncF), 0);
    chk({tag, ".bright"}, 32'(brightF), 0);
    chk({tag, ".pixTick"}, 32'(pixTickF), 0);
    chk({tag, ".frameStart"}, 32'(frameStartF), 0);
  endtask

  task automatic checkSmallZero(input string tag);
    chk({tag, ".hCount"}, 32'(hCountS), 0);
    chk({tag, ".vCount"}, 32'(vCountS), 0);
    chk({tag, ".hSync"}, 32'(hSyncS), 0);
    chk({tag, ".vSync"}, 32'(vSyncS), 0);
    chk({tag, ".bright"}, 32'(brightS), 0);
    chk({tag, ".pixTick"}, 32'(pixTickS), 0);
    chk({tag, ".frameStart"}, 32'(frameStartS), 0);
  endtask

  initial begin
    int guard;

    // Reset hold: ten cycles with both instances in reset.
    #2;
    checkFullZero("rstHoldF");
    checkSmallZero("rstHoldS");
    cycles(10);

    @(negedge clk);
    rstF = 1'b1;
    rstS = 1'b1;
    cyc++;
    lineStart = cyc;
    syncPrev();
    cycles(3);
    chk("F.noTickBeforeEdge4", 32'(pixTickF), 0);
    cycles(1);
    chk("F.firstTickEdge4", 32'(pixTickF), 1);
    chk("F.firstTickH", 32'(hCountF), 1);

    // Full line plus a random tail; small raster runs through two frames.
    cycles(4000 + int'($urandom_range(0, 200)));

    // Mid-line asynchronous reset of the full instance at (500, 1).
    guard = 0;
    while (!(hCountF == 10'd500 && vCountF == 10'd1) && guard < 6000) begin
      cycles(1);
      guard++;
    end
    chk("F.reachedMidLine", 32'(hCountF == 10'd500 && vCountF == 10'd1), 1);
    #($urandom_range(1, 3));
    rstF = 1'b0;
    #1;
    checkFullZero("asyncRstF");
    syncPrev();
    cycles(int'($urandom_range(2, 10)));
    @(negedge clk);
    rstF = 1'b1;
    cyc++;
    lineStart = cyc;
    syncPrev();
    cycles(3);
    chk("F.restartNoTick", 32'(pixTickF), 0);
    cycles(1);
    chk("F.restartTick", 32'(pixTickF), 1);
    chk("F.restartH", 32'(hCountF), 1);

    // Mid-frame asynchronous reset of the small instance at (20, 7).
    guard = 0;
    while (!(hCountS == 10'd20 && vCountS == 10'd7) && guard < 3000) begin
      cycles(1);
      guard++;
    end
    chk("S.reachedMidFrame", 32'(hCountS == 10'd20 && vCountS == 10'd7), 1);
    #($urandom_range(1, 3));
    rstS = 1'b0;
    #1;
    checkSmallZero("asyncRstS");
    seenFs = 0;
    syncPrev();
    cycles(int'($urandom_range(2, 10)));
    @(negedge clk);
    rstS = 1'b1;
    cyc++;
    syncPrev();
    cycles(3);
    chk("S.restartNoTick", 32'(pixTickS), 0);
    cycles(1);
    chk("S.restartTick", 32'(pixTickS), 1);
    chk("S.restartH", 32'(hCountS), 1);

    // Two more small frames after the restart.
    cycles(2 * S_FRAME_CLK + 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
